pc_unit: RTL and testbench

Parametrised program-counter unit, the next generation of the CPU's PC register. It supports the following operations:
- hold
- sequential increment
- absolute load
- PC-relative branch
- call/return through an internal return-address stack (RAS)

It sits between the control unit (which drives pc_op and enable) and the instruction-memory address path. The PC output feeds the MAR and the branch adder.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_ras.sv | 64 ++++++
 rtl/pc_unit.sv | 78 +++++++
 tb/tb_pc_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-counter operation encodings and PC defaults.
package cpu_pkg;

  localparam int unsigned PC_OP_W = 3;
  typedef logic [PC_OP_W-1:0] pc_op_t;

  localparam pc_op_t PC_HOLD   = 3'd0;
  localparam pc_op_t PC_INC    = 3'd1;
  localparam pc_op_t PC_LOAD   = 3'd2;
  localparam pc_op_t PC_BRANCH = 3'd3;
  localparam pc_op_t PC_CALL   = 3'd4;
  localparam pc_op_t PC_RET    = 3'd5;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_STEP      = 4;
  localparam int unsigned DEF_RAS_DEPTH = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_RESET_VECTOR = '0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with occupancy count and sticky
// overflow/underflow detection.
module pc_ras #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             flags_clr,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;

  // ptr is the next write slot; once full it also points at the oldest entry
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(RAS_DEPTH));
  assign top_data = mem[ptr - PTR_W'(1)];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // a set later in this block overrides the clear
      if (flags_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (push) begin
        ptr <= ptr + PTR_W'(1);
        if (full) overflow <= 1'b1;
        else      count    <= count + CNT_W'(1);
      end else if (pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          ptr   <= ptr - PTR_W'(1);
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Storage carries no reset; contents are meaningless until pushed
  always_ff @(posedge clock) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, op decode and next-PC selection,
// with call/return handled through an internal return-address stack.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int unsigned     STEP         = DEF_STEP,
  parameter int unsigned     RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [2:0]       pc_op,
  input  logic [WIDTH-1:0] instruct_PC,
  input  logic [WIDTH-1:0] offset,
  input  logic             flags_clr,
  output logic [WIDTH-1:0] PC,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;

  assign pc_seq = PC + WIDTH'(STEP);

  // Next-PC select; a stalled cycle leaves PC and the stack untouched
  always_comb begin
    pc_next  = PC;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (enable) begin
      case (pc_op)
        PC_INC:    pc_next = pc_seq;
        PC_LOAD:   pc_next = instruct_PC;
        PC_BRANCH: pc_next = PC + offset;
        PC_CALL: begin
          ras_push = 1'b1;
          pc_next  = instruct_PC;
        end
        PC_RET: begin
          ras_pop = 1'b1;
          pc_next = ras_empty ? pc_seq : ras_top;
        end
        default:   pc_next = PC;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) PC <= RESET_VECTOR;
    else        PC <= pc_next;
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .clear     (clear),
    .push      (ras_push),
    .pop       (ras_pop),
    .flags_clr (flags_clr),
    .push_data (pc_seq),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pc_unit;
  import cpu_pkg::*;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned STEPB = 4;
  localparam logic [31:0] RV    = 32'h0;

  logic        clock = 1'b0;
  logic        clear;
  logic        enable;
  logic [2:0]  pc_op;
  logic [31:0] instruct_PC;
  logic [31:0] offset;
  logic        flags_clr;
  logic [31:0] PC;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  always #5 clock = ~clock;

  pc_unit #(
    .WIDTH(W), .RESET_VECTOR(RV), .STEP(STEPB), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .clear(clear), .enable(enable), .pc_op(pc_op),
    .instruct_PC(instruct_PC), .offset(offset), .flags_clr(flags_clr),
    .PC(PC), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue holds return addresses, oldest at the front
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_ovf, m_unf, set_o, set_u;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_pc = RV;
      m_ras.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      set_o = 0;
      set_u = 0;
      if (enable) begin
        case (pc_op)
          3'd1: m_pc = m_pc + STEPB;
          3'd2: m_pc = instruct_PC;
          3'd3: m_pc = m_pc + offset;
          3'd4: begin
            m_ras.push_back(m_pc + STEPB);
            if (m_ras.size() > DEPTH) begin
              void'(m_ras.pop_front());
              set_o = 1;
            end
            m_pc = instruct_PC;
          end
          3'd5: begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
              m_pc  = m_pc + STEPB;
              set_u = 1;
            end
          end
          default: ;
        endcase
      end
      m_ovf = (m_ovf && !flags_clr) || set_o;
      m_unf = (m_unf && !flags_clr) || set_u;
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("pc",        PC,                m_pc);
      chk("empty",     32'(ras_empty),     32'(m_ras.size() == 0));
      chk("full",      32'(ras_full),      32'(m_ras.size() == DEPTH));
      chk("overflow",  32'(ras_overflow),  32'(m_ovf));
      chk("underflow", 32'(ras_underflow), 32'(m_unf));
    end
  end

  task automatic drive(input bit en, input logic [2:0] op, input logic [31:0] ip,
                       input logic [31:0] off, input bit fc);
    enable      = en;
    pc_op       = op;
    instruct_PC = ip;
    offset      = off;
    flags_clr   = fc;
    @(negedge clock);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] ip);
    drive(1'b1, op, ip, 32'h0, 1'b0);
  endtask

  logic [2:0] rop;
  int         r;

  initial begin
    clear = 1'b0;
    enable = 1'b0; pc_op = PC_HOLD; instruct_PC = '0; offset = '0; flags_clr = 1'b0;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    checking = 1;
    chk("reset_pc", PC, 32'h0);
    chk("reset_empty", 32'(ras_empty), 32'h1);
    chk("reset_full", 32'(ras_full), 32'h0);

    // Mid-run asynchronous reset with a non-empty stack
    run(PC_CALL, 32'h40);
    chk("pre_clear_pc", PC, 32'h40);
    #2 clear = 1'b0;
    #1 chk("async_clear_pc", PC, 32'h0);
    chk("async_clear_empty", 32'(ras_empty), 32'h1);
    @(negedge clock);
    clear = 1'b1;
    run(PC_INC, 0); chk("inc1", PC, 32'h4);
    run(PC_INC, 0); chk("inc2", PC, 32'h8);
    run(PC_INC, 0); chk("inc3", PC, 32'hC);
    chk("inc_empty", 32'(ras_empty), 32'h1);

    run(PC_LOAD, 32'h100); chk("load", PC, 32'h100);
    drive(1'b1, PC_BRANCH, 0, 32'hFFFF_FFF0, 1'b0); chk("branch_back", PC, 32'hF0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, PC_INC, 32'h1234, 32'h0, 1'b0);
      chk("stall", PC, 32'hF0);
    end

    run(PC_LOAD, 32'hFFFF_FFFC);
    run(PC_INC, 0); chk("wrap", PC, 32'h0);
    chk("wrap_ovf", 32'(ras_overflow), 32'h0);
    chk("wrap_unf", 32'(ras_underflow), 32'h0);

    run(PC_LOAD, 32'h10);
    run(PC_CALL, 32'h200); chk("call1", PC, 32'h200);
    run(PC_CALL, 32'h300); chk("call2", PC, 32'h300);
    run(PC_RET, 0); chk("ret1", PC, 32'h204);
    run(PC_RET, 0); chk("ret2", PC, 32'h14);
    chk("nest_empty", 32'(ras_empty), 32'h1);

    run(PC_LOAD, 32'h0);
    for (int i = 1; i <= 5; i++) run(PC_CALL, 32'(i) * 32'h100);
    chk("ovf_flag", 32'(ras_overflow), 32'h1);
    chk("ovf_full", 32'(ras_full), 32'h1);
    run(PC_RET, 0); chk("ovf_ret1", PC, 32'h404);
    run(PC_RET, 0); chk("ovf_ret2", PC, 32'h304);
    run(PC_RET, 0); chk("ovf_ret3", PC, 32'h204);
    run(PC_RET, 0); chk("ovf_ret4", PC, 32'h104);
    chk("ovf_drained", 32'(ras_empty), 32'h1);

    run(PC_LOAD, 32'h50);
    run(PC_RET, 0); chk("unf_pc", PC, 32'h54);
    chk("unf_flag", 32'(ras_underflow), 32'h1);
    drive(1'b1, PC_RET, 0, 0, 1'b1); chk("unf_set_wins_pc", PC, 32'h58);
    chk("unf_set_wins", 32'(ras_underflow), 32'h1);
    drive(1'b0, PC_HOLD, 0, 0, 1'b1);
    chk("flags_clr_unf", 32'(ras_underflow), 32'h0);
    chk("flags_clr_ovf", 32'(ras_overflow), 32'h0);

    // Random traffic with occasional asynchronous reset pulses
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 clear = 1'b0;
        #2 clear = 1'b1;
      end
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    rop = PC_INC;
        2:       rop = PC_LOAD;
        3:       rop = PC_BRANCH;
        4, 5:    rop = PC_CALL;
        6, 7:    rop = PC_RET;
        8:       rop = PC_HOLD;
        default: rop = 3'($urandom_range(6, 7));
      endcase
      drive(($urandom_range(0, 7) != 0), rop,
            ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_FFFC),
            32'($signed(16'($urandom))),
            ($urandom_range(0, 15) == 0));
    end

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
